usb_reg_seq_master: RTL and testbench

- Synthesizable USB parallel-bus master for the CW305 register interface.
- Executes queued register commands against the target's register map: multi-byte WRITE, multi-byte READ, and RUN (write GO, then poll busy until clear).
- Generalises the byte-level write/read/poll sequences to parametric burst width and poll limits.
- Used for on-FPGA self-test of the crypto/poly-mult cores and as a loopback driver for the USB register front end.

---
 rtl/usb_reg_seq_master_if.sv | 40 ++++
 rtl/usb_reg_seq_master.sv | 203 ++++++++++++++++++++
 tb/tb_usb_reg_seq_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_reg_seq_master_if.sv
// Command/response handshake plus the CW305 parallel register bus driven by usb_reg_seq_master.
// The master modport is the sequencer's view; the slave modport is the command source / bus target.
interface usb_reg_seq_master_if #(
   parameter int pADDR_WIDTH = 21,
   parameter int pMAX_BYTES  = 32
);
   localparam int NB_W = $clog2(pMAX_BYTES + 1);

   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [1:0]              cmd_op;
   logic [1:0]              cmd_block;
   logic [5:0]              cmd_addr;
   logic [NB_W-1:0]         cmd_nbytes;
   logic [pMAX_BYTES*8-1:0] cmd_wdata;

   logic                    rsp_valid;
   logic [pMAX_BYTES*8-1:0] rsp_rdata;
   logic [1:0]              rsp_err;

   logic [pADDR_WIDTH-1:0]  usb_addr;
   logic [7:0]              usb_wdata;
   logic                    usb_data_oe;
   logic [7:0]              usb_rdata;
   logic                    usb_rdn;
   logic                    usb_wrn;
   logic                    usb_cen;

   modport master (
      input  cmd_valid, cmd_op, cmd_block, cmd_addr, cmd_nbytes, cmd_wdata, usb_rdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             usb_addr, usb_wdata, usb_data_oe, usb_rdn, usb_wrn, usb_cen
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_block, cmd_addr, cmd_nbytes, cmd_wdata, usb_rdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             usb_addr, usb_wdata, usb_data_oe, usb_rdn, usb_wrn, usb_cen
   );
endinterface

// File: rtl/usb_reg_seq_master.sv
// Register-command sequencer for the CW305 USB parallel bus: multi-byte WRITE, multi-byte READ
// and RUN (write GO, then poll busy with a gap until clear or until the poll limit expires).
module usb_reg_seq_master #(
   parameter int         pADDR_WIDTH   = 21,
   parameter int         pBYTECNT_SIZE = 7,
   parameter int         pMAX_BYTES    = 32,
   parameter logic [5:0] pGO_ADDR      = 6'd5,
   parameter int         pPOLL_GAP     = 5,
   parameter int         pPOLL_LIMIT   = 1024
) (
   input  logic                 usb_clk,
   input  logic                 pushbutton,
   usb_reg_seq_master_if.master bus
);
   localparam int NB_W   = $clog2(pMAX_BYTES + 1);
   localparam int IDX_W  = (pMAX_BYTES > 1) ? $clog2(pMAX_BYTES) : 1;
   localparam int GAP_W  = $clog2(pPOLL_GAP + 1);
   localparam int POLL_W = $clog2(pPOLL_LIMIT + 1);
   localparam int DW     = pMAX_BYTES * 8;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_RUN   = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   typedef enum logic [3:0] {
      IDLE, W0, W1, W2, W3, W4, R0, R1, R2, R3, R4, R5, GAP, RESP
   } state_t;

   state_t            state;
   logic [1:0]        op_q;
   logic [1:0]        block_q;
   logic [5:0]        addr_q;
   logic [NB_W-1:0]   nbytes_q;
   logic [DW-1:0]     wdata_q;
   logic [IDX_W-1:0]  byte_idx;
   logic [GAP_W-1:0]  gap_cnt;
   logic [POLL_W-1:0] poll_cnt;
   logic              busy_q;

   logic [IDX_W-1:0]  next_idx;
   logic              last_byte;
   logic              cmd_illegal;
   logic              cmd_is_run;

   assign next_idx    = byte_idx + IDX_W'(1);
   assign last_byte   = (NB_W'(byte_idx) + NB_W'(1)) == nbytes_q;
   assign cmd_is_run  = bus.cmd_op == OP_RUN;
   assign cmd_illegal = (bus.cmd_op == OP_RSVD) || (bus.cmd_nbytes == '0) ||
                        (bus.cmd_nbytes > NB_W'(pMAX_BYTES));

   function automatic logic [pADDR_WIDTH-1:0] bus_addr(input logic [1:0] blk,
                                                       input logic [5:0] reg_addr,
                                                       input logic [IDX_W-1:0] idx);
      bus_addr = '0;
      bus_addr[pBYTECNT_SIZE +: 8]  = {blk, reg_addr};
      bus_addr[pBYTECNT_SIZE-1:0]   = pBYTECNT_SIZE'(idx);
   endfunction

   // Every output is set on entry to the state whose behaviour it belongs to.
   always_ff @(posedge usb_clk or negedge pushbutton) begin
      if (!pushbutton) begin
         state           <= IDLE;
         op_q            <= OP_WRITE;
         block_q         <= '0;
         addr_q          <= '0;
         nbytes_q        <= '0;
         wdata_q         <= '0;
         byte_idx        <= '0;
         gap_cnt         <= '0;
         poll_cnt        <= '0;
         busy_q          <= 1'b0;
         bus.cmd_ready   <= 1'b1;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rdata   <= '0;
         bus.rsp_err     <= 2'd0;
         bus.usb_addr    <= '0;
         bus.usb_wdata   <= '0;
         bus.usb_data_oe <= 1'b0;
         bus.usb_rdn     <= 1'b1;
         bus.usb_wrn     <= 1'b1;
         bus.usb_cen     <= 1'b1;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid && bus.cmd_ready) begin
                  bus.cmd_ready <= 1'b0;
                  op_q          <= bus.cmd_op;
                  block_q       <= bus.cmd_block;
                  byte_idx      <= '0;
                  poll_cnt      <= '0;
                  if (cmd_illegal) begin
                     bus.rsp_err   <= 2'd2;
                     bus.rsp_valid <= 1'b1;
                     state         <= RESP;
                  end else if (bus.cmd_op == OP_READ) begin
                     addr_q        <= bus.cmd_addr;
                     nbytes_q      <= bus.cmd_nbytes;
                     bus.rsp_rdata <= '0;
                     bus.usb_addr  <= bus_addr(bus.cmd_block, bus.cmd_addr, '0);
                     state         <= R0;
                  end else begin
                     // RUN reuses the write path as a one-byte write of 0x01 to the GO register.
                     addr_q          <= cmd_is_run ? pGO_ADDR : bus.cmd_addr;
                     nbytes_q        <= cmd_is_run ? NB_W'(1) : bus.cmd_nbytes;
                     wdata_q         <= cmd_is_run ? DW'(1) : bus.cmd_wdata;
                     if (cmd_is_run)
                        bus.rsp_rdata <= '0;
                     bus.usb_addr    <= bus_addr(bus.cmd_block,
                                                 cmd_is_run ? pGO_ADDR : bus.cmd_addr, '0);
                     bus.usb_wdata   <= cmd_is_run ? 8'h01 : bus.cmd_wdata[7:0];
                     bus.usb_wrn     <= 1'b0;
                     bus.usb_data_oe <= 1'b1;
                     state           <= W0;
                  end
               end
            end
            W0: begin
               bus.usb_cen <= 1'b0;
               state       <= W1;
            end
            W1: begin
               bus.usb_cen <= 1'b1;
               state       <= W2;
            end
            W2: begin
               bus.usb_wrn <= 1'b1;
               state       <= W3;
            end
            W3: begin
               if (last_byte)
                  bus.usb_data_oe <= 1'b0;
               state <= W4;
            end
            W4: begin
               if (!last_byte) begin
                  byte_idx        <= next_idx;
                  bus.usb_addr    <= bus_addr(block_q, addr_q, next_idx);
                  bus.usb_wdata   <= wdata_q[{next_idx, 3'b000} +: 8];
                  bus.usb_wrn     <= 1'b0;
                  bus.usb_data_oe <= 1'b1;
                  state           <= W0;
               end else if (op_q == OP_RUN) begin
                  gap_cnt <= '0;
                  state   <= GAP;
               end else begin
                  bus.rsp_err   <= 2'd0;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end
            end
            R0: begin
               bus.usb_rdn <= 1'b0;
               bus.usb_cen <= 1'b0;
               state       <= R1;
            end
            R1: state <= R2;
            R2: state <= R3;
            R3: begin
               bus.rsp_rdata[{byte_idx, 3'b000} +: 8] <= bus.usb_rdata;
               busy_q      <= bus.usb_rdata[0];
               bus.usb_rdn <= 1'b1;
               bus.usb_cen <= 1'b1;
               state       <= R4;
            end
            R4: state <= R5;
            R5: begin
               if (!last_byte) begin
                  byte_idx     <= next_idx;
                  bus.usb_addr <= bus_addr(block_q, addr_q, next_idx);
                  state        <= R0;
               end else if (op_q != OP_RUN || !busy_q) begin
                  bus.rsp_err   <= 2'd0;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end else if (poll_cnt == POLL_W'(pPOLL_LIMIT - 1)) begin
                  bus.rsp_err   <= 2'd1;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end else begin
                  poll_cnt <= poll_cnt + POLL_W'(1);
                  gap_cnt  <= '0;
                  state    <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(pPOLL_GAP - 1)) begin
                  bus.usb_addr <= bus_addr(block_q, addr_q, '0);
                  state        <= R0;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            RESP: begin
               bus.cmd_ready <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_usb_reg_seq_master.sv
// Table-driven bench for usb_reg_seq_master: register slave model, bus monitor, and
// hand-written reset sequences around a vector table of WRITE/READ/RUN/illegal commands.
module tb_usb_reg_seq_master;
   localparam int pMAX_BYTES = 32;
   localparam int NB_W       = $clog2(pMAX_BYTES + 1);
   localparam int DW         = pMAX_BYTES * 8;
   localparam int NVEC       = 11;

   logic usb_clk    = 1'b0;
   logic pushbutton = 1'b1;
   always #5 usb_clk = ~usb_clk;

   usb_reg_seq_master_if #(.pADDR_WIDTH(21), .pMAX_BYTES(pMAX_BYTES)) bus ();

   usb_reg_seq_master #(.pPOLL_LIMIT(8)) dut (
      .usb_clk    (usb_clk),
      .pushbutton (pushbutton),
      .bus        (bus.master)
   );

   typedef struct {
      logic [1:0]    op;
      logic [1:0]    blk;
      logic [5:0]    adr;
      int            nbytes;
      logic [DW-1:0] wdata;
      int            busy;
      logic [1:0]    err;
      int            lat;
      int            writes;
      int            reads;
   } vec_t;

   vec_t vecs[NVEC];
   int   total = 0;
   int   bad   = 0;

   // Slave: GO register reports busy for the first busy_polls polls, other addresses read rd_mem.
   logic [7:0]  rd_mem [32];
   int          poll_seen  = 0;
   int          busy_polls = 0;
   logic        busy_now;
   assign busy_now      = poll_seen <= busy_polls;
   assign bus.usb_rdata = (bus.usb_addr[12:7] == 6'd5) ? {7'b0, busy_now} : rd_mem[bus.usb_addr[4:0]];

   logic        prev_cen = 1'b1;
   logic [20:0] wr_addr_q[$];
   logic [7:0]  wr_data_q[$];
   int          n_reads    = 0;
   int          viol       = 0;
   int          rsp_pulses = 0;

   always @(negedge usb_clk) begin
      if (prev_cen && !bus.usb_cen) begin
         if (!bus.usb_wrn) begin
            wr_addr_q.push_back(bus.usb_addr);
            wr_data_q.push_back(bus.usb_wdata);
         end else if (!bus.usb_rdn) begin
            n_reads++;
            poll_seen++;
         end
      end
      if (!bus.usb_wrn && !bus.usb_rdn) viol++;
      if (bus.usb_data_oe && !bus.usb_rdn) viol++;
      if (bus.rsp_valid) rsp_pulses++;
      prev_cen = bus.usb_cen;
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v, output int lat, output logic [1:0] err,
                                output logic [DW-1:0] rdata, output logic timed_out);
      @(negedge usb_clk);
      bus.cmd_op     = v.op;
      bus.cmd_block  = v.blk;
      bus.cmd_addr   = v.adr;
      bus.cmd_nbytes = NB_W'(v.nbytes);
      bus.cmd_wdata  = v.wdata;
      bus.cmd_valid  = 1'b1;
      @(posedge usb_clk);
      lat       = 0;
      err       = 2'd0;
      rdata     = '0;
      timed_out = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge usb_clk);
         lat++;
         if (lat == 1) begin
            checkOutput("ready_low", bus.cmd_ready, 0);
            bus.cmd_wdata = ~v.wdata;
            bus.cmd_addr  = ~v.adr;
            bus.cmd_block = ~v.blk;
         end
         if (bus.rsp_valid) begin
            err       = bus.rsp_err;
            rdata     = bus.rsp_rdata;
            timed_out = 1'b0;
            break;
         end
      end
      bus.cmd_valid = 1'b0;
      @(negedge usb_clk);
      checkOutput("ready_back", bus.cmd_ready, 1);
      checkOutput("rsp_one_cycle", bus.rsp_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int            lat;
      logic [1:0]    err;
      logic [DW-1:0] rdata;
      logic          to;
      logic [DW-1:0] exp_rdata;
      logic [127:0]  rd_init;
      logic [20:0]   ea;
      logic [7:0]    ed;
      logic [5:0]    eadr;

      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 2'd0;
      bus.cmd_block  = 2'd0;
      bus.cmd_addr   = 6'd0;
      bus.cmd_nbytes = '0;
      bus.cmd_wdata  = '0;

      rd_init = 128'h8a278bf8fa2812bc39e52c76205af377;
      for (int i = 0; i < 16; i++) rd_mem[i] = rd_init[i*8 +: 8];
      for (int i = 16; i < 32; i++) rd_mem[i] = 8'h40 + 8'(i);

      //         op     blk    adr     n   wdata                                                                  busy  err    lat  wr  rd
      vecs[0]  = '{2'd0, 2'd0, 6'd3,   4,  256'hdeadbeef,                                                         0,    2'd0,  21,  4,  0};
      vecs[1]  = '{2'd1, 2'd0, 6'd3,   16, 256'h0,                                                                0,    2'd0,  97,  0,  16};
      vecs[2]  = '{2'd0, 2'd2, 6'h3f,  1,  256'ha5,                                                               0,    2'd0,  6,   1,  0};
      vecs[3]  = '{2'd1, 2'd1, 6'h10,  1,  256'h0,                                                                0,    2'd0,  7,   0,  1};
      vecs[4]  = '{2'd0, 2'd3, 6'h2a,  32, 256'h0123456789abcdeffedcba987654321055aa33cc0f1e2d3c4b5a69788796a5b4, 0,    2'd0,  161, 32, 0};
      vecs[5]  = '{2'd0, 2'd0, 6'd3,   0,  256'h11,                                                               0,    2'd2,  1,   0,  0};
      vecs[6]  = '{2'd0, 2'd0, 6'd3,   33, 256'h22,                                                               0,    2'd2,  1,   0,  0};
      vecs[7]  = '{2'd3, 2'd0, 6'd3,   1,  256'h33,                                                               0,    2'd2,  1,   0,  0};
      vecs[8]  = '{2'd2, 2'd1, 6'd0,   1,  256'h0,                                                                3,    2'd0,  50,  1,  4};
      vecs[9]  = '{2'd2, 2'd2, 6'd0,   1,  256'h0,                                                                1000, 2'd1,  94,  1,  8};
      vecs[10] = '{2'd2, 2'd0, 6'd0,   1,  256'h0,                                                                0,    2'd0,  17,  1,  1};

      #2 pushbutton = 1'b0;
      #1;
      checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
      checkOutput("rst_rdn", bus.usb_rdn, 1);
      checkOutput("rst_wrn", bus.usb_wrn, 1);
      checkOutput("rst_cen", bus.usb_cen, 1);
      checkOutput("rst_oe", bus.usb_data_oe, 0);
      checkOutput("rst_addr", bus.usb_addr, 0);
      checkOutput("rst_wdata", bus.usb_wdata, 0);
      checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
      checkOutput("rst_rsp_err", bus.rsp_err, 0);
      checkOutput("rst_rsp_rdata", bus.rsp_rdata, 0);
      repeat (2) @(negedge usb_clk);
      pushbutton = 1'b1;

      exp_rdata = '0;
      for (int i = 0; i < NVEC; i++) begin
         wr_addr_q.delete();
         wr_data_q.delete();
         n_reads    = 0;
         poll_seen  = 0;
         busy_polls = vecs[i].busy;
         applyStimulus(vecs[i], lat, err, rdata, to);
         checkOutput($sformatf("v%0d_rsp_seen", i), to, 0);
         checkOutput($sformatf("v%0d_err", i), err, vecs[i].err);
         checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         checkOutput($sformatf("v%0d_nwrites", i), wr_addr_q.size(), vecs[i].writes);
         checkOutput($sformatf("v%0d_nreads", i), n_reads, vecs[i].reads);
         for (int k = 0; k < wr_addr_q.size() && k < vecs[i].writes; k++) begin
            eadr = (vecs[i].op == 2'd2) ? 6'd5 : vecs[i].adr;
            ed   = (vecs[i].op == 2'd2) ? 8'h01 : vecs[i].wdata[k*8 +: 8];
            ea   = {6'b0, vecs[i].blk, eadr, 7'(k)};
            checkOutput($sformatf("v%0d_wr%0d_addr", i, k), wr_addr_q[k], ea);
            checkOutput($sformatf("v%0d_wr%0d_data", i, k), wr_data_q[k], ed);
         end
         if (vecs[i].op == 2'd1 && vecs[i].err == 2'd0) begin
            exp_rdata = '0;
            for (int k = 0; k < vecs[i].nbytes; k++) exp_rdata[k*8 +: 8] = rd_mem[k];
         end else if (vecs[i].op == 2'd2 && vecs[i].err != 2'd2) begin
            exp_rdata = (vecs[i].err == 2'd1) ? DW'(1) : DW'(0);
         end
         checkOutput($sformatf("v%0d_rdata", i), rdata, exp_rdata);
      end

      // Reset asserted during W1 of the second byte of a 4-byte WRITE.
      wr_addr_q.delete();
      wr_data_q.delete();
      @(negedge usb_clk);
      bus.cmd_op     = 2'd0;
      bus.cmd_block  = 2'd0;
      bus.cmd_addr   = 6'd3;
      bus.cmd_nbytes = NB_W'(4);
      bus.cmd_wdata  = 256'h11223344;
      bus.cmd_valid  = 1'b1;
      @(posedge usb_clk);
      @(negedge usb_clk);
      bus.cmd_valid = 1'b0;
      repeat (6) @(negedge usb_clk);
      checkOutput("mid_cen_low", bus.usb_cen, 0);
      checkOutput("mid_wrn_low", bus.usb_wrn, 0);
      checkOutput("mid_addr_byte1", bus.usb_addr, 21'h181);
      rsp_pulses = 0;
      pushbutton = 1'b0;
      #1;
      checkOutput("async_wrn", bus.usb_wrn, 1);
      checkOutput("async_cen", bus.usb_cen, 1);
      checkOutput("async_rdn", bus.usb_rdn, 1);
      checkOutput("async_oe", bus.usb_data_oe, 0);
      repeat (3) @(negedge usb_clk);
      pushbutton = 1'b1;
      repeat (40) @(negedge usb_clk);
      checkOutput("abandon_no_rsp", rsp_pulses, 0);
      checkOutput("abandon_ready", bus.cmd_ready, 1);
      checkOutput("abandon_cen", bus.usb_cen, 1);

      wr_addr_q.delete();
      wr_data_q.delete();
      n_reads = 0;
      applyStimulus(vecs[0], lat, err, rdata, to);
      checkOutput("post_rst_rsp_seen", to, 0);
      checkOutput("post_rst_err", err, 0);
      checkOutput("post_rst_latency", lat, 21);
      checkOutput("post_rst_nwrites", wr_addr_q.size(), 4);
      if (wr_data_q.size() == 4) begin
         checkOutput("post_rst_byte3", wr_data_q[3], 8'hde);
         checkOutput("post_rst_addr3", wr_addr_q[3], 21'h183);
      end

      checkOutput("strobe_rules", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
